// File: rtl/dff_pipe_if.sv
// dff_pipe_if: control, data and status bundle for dff_pipe
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int FW = $clog2(DEPTH + 1);
  logic CE, SSET, VI, VO;
  logic [WIDTH-1:0] D, Q;
  logic [FW-1:0] FILL;
  modport master (output CE, SSET, VI, D, input Q, VO, FILL);
  modport slave (input CE, SSET, VI, D, output Q, VO, FILL);
endinterface

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one data+valid register with CLEAR > SSET > CE priority
module dff_pipe_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '1,
  parameter logic [WIDTH-1:0] SYNC_VAL = '1
) (
  input  logic CLK,
  input  logic CLEAR,
  input  logic CE,
  input  logic SSET,
  input  logic VI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic VO
);
  logic [WIDTH:0] r_d;
  logic [WIDTH:0] r_q = {1'b0, INIT};
  always_comb r_d = SSET ? {1'b0, SYNC_VAL} : CE ? {VI, D} : r_q;
  always_ff @(posedge CLK or posedge CLEAR)
    if (CLEAR) r_q <= {1'b0, INIT};
    else r_q <= r_d;
  assign {VO, Q} = r_q;
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage registered data/valid pipe with an occupancy counter
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = '1,
  parameter logic [WIDTH-1:0] SYNC_VAL = '1
) (
  input logic CLK,
  input logic CLEAR,
  dff_pipe_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] d_s [DEPTH+1];
  logic [DEPTH:0] v_s;
  logic [FW-1:0] fill_d;
  logic [FW-1:0] fill_q = '0;
  assign d_s[0] = bus.D;
  assign v_s[0] = bus.VI;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_pipe_stage #(.WIDTH(WIDTH), .INIT(INIT), .SYNC_VAL(SYNC_VAL)) u_stage (
      .CLK(CLK),
      .CLEAR(CLEAR),
      .CE(bus.CE),
      .SSET(bus.SSET),
      .VI(v_s[i]),
      .D(d_s[i]),
      .Q(d_s[i+1]),
      .VO(v_s[i+1])
    );
  end
  // occupancy tracks entries in minus entries dropped off the end
  always_comb fill_d = bus.SSET ? '0 : bus.CE ? fill_q + FW'(bus.VI) - FW'(v_s[DEPTH]) : fill_q;
  always_ff @(posedge CLK or posedge CLEAR)
    if (CLEAR) fill_q <= '0;
    else fill_q <= fill_d;
  assign bus.Q = d_s[DEPTH];
  assign bus.VO = v_s[DEPTH];
  assign bus.FILL = fill_q;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: randomized and directed checks of dff_pipe against a queue model
module tb_dff_pipe;
  logic clk = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  int checks = 0;
  int errors = 0;
  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) a ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1)) b ();
  dff_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'hFF), .SYNC_VAL(8'hA5)) u_a (
    .CLK(clk), .CLEAR(clr_a), .bus(a));
  dff_pipe #(.WIDTH(1), .DEPTH(1), .INIT(1'b1), .SYNC_VAL(1'b0)) u_b (
    .CLK(clk), .CLEAR(clr_b), .bus(b));
  always #5 clk = ~clk;
  // model: queue of {valid,data}, front is the newest entry, back is what Q shows
  logic [8:0] qa [$];
  logic [1:0] qb [$];
  task automatic reset_a();
    qa.delete();
    repeat (4) qa.push_back(9'h0FF);
  endtask
  task automatic reset_b();
    qb.delete();
    qb.push_back(2'b01);
  endtask
  function automatic int pop_a();
    int n = 0;
    foreach (qa[i]) n += int'(qa[i][8]);
    return n;
  endfunction
  task automatic model_edge();
    if (a.SSET) foreach (qa[i]) qa[i] = 9'h0A5;
    else if (a.CE) begin
      qa.push_front({a.VI, a.D});
      void'(qa.pop_back());
    end
    if (b.SSET) qb[0] = 2'b00;
    else if (b.CE) begin
      qb.push_front({b.VI, b.D});
      void'(qb.pop_back());
    end
  endtask
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmp_all(string tag);
    chk({tag, ":a.Q"}, 64'(a.Q), 64'(qa[3][7:0]));
    chk({tag, ":a.VO"}, 64'(a.VO), 64'(qa[3][8]));
    chk({tag, ":a.FILL"}, 64'(a.FILL), 64'(pop_a()));
    chk({tag, ":b.Q"}, 64'(b.Q), 64'(qb[0][0]));
    chk({tag, ":b.VO"}, 64'(b.VO), 64'(qb[0][1]));
    chk({tag, ":b.FILL"}, 64'(b.FILL), 64'(qb[0][1]));
  endtask
  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    cmp_all(tag);
  endtask
  initial begin
    a.CE = 1'b0; a.SSET = 1'b0; a.VI = 1'b0; a.D = '0;
    b.CE = 1'b0; b.SSET = 1'b0; b.VI = 1'b0; b.D = '0;
    reset_a();
    reset_b();
    #1;
    cmp_all("t0");
    chk("t0_q", 64'(a.Q), 64'hFF);
    clr_a = 1'b1;
    clr_b = 1'b1;
    #1;
    cmp_all("clr");
    #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a.CE = 1'b1; a.VI = 1'b1; a.D = 8'(8'h11 * (k + 1));
      b.CE = 1'b1; b.VI = k[0]; b.D = k[0] ^ 1'b1;
      tick("fill");
      chk("fill_cnt", 64'(a.FILL), 64'(k + 1));
      chk("b_q", 64'(b.Q), 64'(k[0] ^ 1'b1));
      chk("b_fill", 64'(b.FILL), 64'(k[0]));
    end
    chk("q_11", 64'(a.Q), 64'h11);
    chk("vo_1", 64'(a.VO), 64'h1);
    a.CE = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a.D = 8'($urandom);
      a.VI = 1'($urandom);
      tick("hold");
      chk("hold_q", 64'(a.Q), 64'h11);
      chk("hold_fill", 64'(a.FILL), 64'h4);
    end
    a.CE = 1'b1; a.VI = 1'b1; a.D = 8'h55;
    tick("resume");
    chk("resume_q", 64'(a.Q), 64'h22);
    a.VI = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick("drain");
      chk("drain_fill", 64'(a.FILL), 64'(3 - k));
    end
    chk("drain_vo", 64'(a.VO), 64'h0);
    a.SSET = 1'b1; a.CE = 1'b0;
    tick("sset");
    chk("sset_q", 64'(a.Q), 64'hA5);
    chk("sset_fill", 64'(a.FILL), 64'h0);
    a.SSET = 1'b0; a.CE = 1'b1; a.VI = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a.D = 8'(8'h60 + k);
      tick("refill");
    end
    chk("refill_cnt", 64'(a.FILL), 64'h3);
    #2;
    clr_a = 1'b1;
    a.SSET = 1'b1;
    #1;
    reset_a();
    cmp_all("midclr");
    chk("midclr_q", 64'(a.Q), 64'hFF);
    chk("midclr_fill", 64'(a.FILL), 64'h0);
    #1;
    clr_a = 1'b0;
    a.SSET = 1'b0;
    a.D = 8'h77;
    tick("post_clr");
    chk("post_clr_fill", 64'(a.FILL), 64'h1);
    for (int n = 0; n < 400; n++) begin
      a.CE = ($urandom % 4) != 0; a.SSET = ($urandom % 16) == 0;
      a.VI = 1'($urandom); a.D = 8'($urandom);
      b.CE = ($urandom % 4) != 0; b.SSET = ($urandom % 16) == 0;
      b.VI = 1'($urandom); b.D = 1'($urandom);
      tick("rnd");
      if ($urandom % 25 == 0) begin
        #2;
        clr_a = 1'b1;
        clr_b = ($urandom % 2) == 0;
        a.SSET = 1'($urandom);
        #1;
        reset_a();
        if (clr_b) reset_b();
        cmp_all("rnd_clr");
        #1;
        clr_a = 1'b0;
        clr_b = 1'b0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages, legal range 1..16.
REQ-003 Parameter INIT, default all-ones (WIDTH bits): value loaded into every data stage by CLEAR and at time zero.
REQ-004 Parameter SYNC_VAL, default all-ones (WIDTH bits): value loaded into every data stage by SSET.
REQ-005 CLK, input, 1 bit: the single clock; all synchronous activity is on its rising edge.
REQ-006 CLEAR, input, 1 bit: reset, asynchronous, active-high.
REQ-007 CE, input, 1 bit: clock enable; the pipe advances only when CE is 1.
REQ-008 SSET, input, 1 bit: synchronous set, active-high; it takes priority over CE.
REQ-009 D, input, WIDTH bits: data into stage 0.
REQ-010 VI, input, 1 bit: marks D as valid.
REQ-011 Q, output, WIDTH bits: content of the last stage (DEPTH-1).
REQ-012 VO, output, 1 bit: valid flag of the last stage.
REQ-013 FILL, output, clog2(DEPTH+1) bits: number of stages currently holding valid data.

Function
REQ-014 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-015 When CE=1 and SSET=0, on each rising CLK edge: stage0 SHALL take D/VI, and stage k SHALL take the old contents of stage k-1.
REQ-016 The latency from D/VI to Q/VO SHALL be exactly DEPTH CE-qualified edges.
REQ-017 When CE=0 and SSET=0, all stages, valid flags and FILL SHALL hold their values.
REQ-018 When SSET=1 on a rising edge, regardless of CE: every data stage SHALL load SYNC_VAL, every valid flag SHALL clear to 0, and FILL SHALL become 0.
REQ-019 On a CE advance, FILL SHALL become the old FILL + VI − old VO; this sum SHALL never leave the range 0..DEPTH.
REQ-020 FILL SHALL equal the population count of the valid flags after every edge.
REQ-021 DEPTH=1 SHALL be a single register stage, with Q equal to D after one CE edge.
REQ-022 There SHALL be no backpressure: data leaving the last stage is discarded.

Reset
REQ-023 While CLEAR=1, regardless of CLK, CE and SSET, the block SHALL immediately force:
- every data stage = INIT;
- Q = INIT;
- every valid flag = 0, VO = 0;
- FILL = 0.
REQ-024 CLEAR SHALL have priority over SSET, which SHALL have priority over CE.
REQ-025 When CLEAR deasserts, the first capture SHALL occur on the next rising CLK edge and follow REQ-015 to REQ-018.
REQ-026 At simulation time zero, before any CLEAR, the block SHALL hold the CLEAR state through an initial assignment that is valid under Verilator.
REQ-027 A CLEAR asserted mid-stream SHALL discard all in-flight data; no partial shift SHALL be observable.

Structure
REQ-028 No shared package SHALL be used; the FILL width SHALL be a local constant derived from DEPTH.
REQ-029 One sub-module, dff_pipe_stage, SHALL be used: a single WIDTH+1-bit register (data plus valid) with CLEAR/SSET/CE priority.
REQ-030 dff_pipe SHALL instantiate dff_pipe_stage DEPTH times via generate, and SHALL hold the FILL counter itself.

Verification
REQ-031 WIDTH=8, DEPTH=4: CLEAR pulse, then CE=1, VI=1 with D=0x11,0x22,0x33,0x44 → Q=0x11 and VO=1 on the 4th edge; FILL reads 1,2,3,4; after reset Q=0xFF.
REQ-032 Pipe full and streaming, VI=0 for 4 edges → FILL reads 3,2,1,0; VO=0 after the 4th edge.
REQ-033 Pipe filled with 0x11..0x44, CE=0 for 5 cycles while D toggles → Q, VO and FILL are unchanged; resume CE → 0x22 appears next.
REQ-034 SSET=1 with CE=0, SYNC_VAL=0xA5 → after one edge Q=0xA5, VO=0, FILL=0.
REQ-035 CLEAR asserted between clock edges with FILL=3 → Q=0xFF, VO=0, FILL=0 before the next edge; SSET asserted simultaneously is ignored.
REQ-036 DEPTH=1, WIDTH=1 → Q follows D after one CE edge; FILL toggles between 0 and 1 with VI.
